// File: rtl/serial_program_loader.sv
// rtl/serial_program_loader.sv - 8N1 serial receiver that unpacks LEN/data/CSUM packets into programming-port writes
module serial_program_loader #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_serial,
   output logic [7:0] prog_data_in,
   output logic [4:0] prog_addr,
   output logic       prog_write_enable,
   output logic       start_execution,
   output logic       busy,
   output logic       frame_error,
   output logic       proto_error
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RECOVER} rx_state_t;
   typedef enum logic [1:0] {P_LEN, P_DATA, P_CSUM} pk_state_t;

   rx_state_t        rx_state, rx_next;
   pk_state_t        pk_state, pk_next;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_byte;
   logic             byte_valid, byte_abort;
   logic             cnt_clr, cnt_inc, sample_data, stop_ok, stop_bad;
   logic [5:0]       len, idx;
   logic [7:0]       sum;
   logic             len_load, len_bad, data_write, csum_ok, csum_bad;

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_serial;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_state <= RX_IDLE;
         pk_state <= P_LEN;
      end else begin
         rx_state <= rx_next;
         pk_state <= pk_next;
      end
   end

   // Start bit is sampled at mid-bit, then every full bit period after that.
   always_comb begin
      rx_next     = rx_state;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      sample_data = 1'b0;
      stop_ok     = 1'b0;
      stop_bad    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_s) begin
               rx_next = RX_START;
               cnt_clr = 1'b1;
            end
         end
         RX_START: begin
            if (clk_cnt == HALF_LAST) begin
               cnt_clr = 1'b1;
               rx_next = rx_s ? RX_IDLE : RX_DATA;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RX_DATA: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_clr     = 1'b1;
               sample_data = 1'b1;
               if (bit_cnt == 3'd7) rx_next = RX_STOP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RX_STOP: begin
            if (clk_cnt == BIT_LAST) begin
               cnt_clr = 1'b1;
               if (rx_s) begin
                  stop_ok = 1'b1;
                  rx_next = RX_IDLE;
               end else begin
                  stop_bad = 1'b1;
                  rx_next  = RX_RECOVER;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         RX_RECOVER: begin
            if (rx_s) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_cnt     <= '0;
         bit_cnt     <= 3'd0;
         rx_byte     <= 8'd0;
         byte_valid  <= 1'b0;
         byte_abort  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         byte_valid <= stop_ok;
         byte_abort <= stop_bad;
         if (cnt_clr)      clk_cnt <= '0;
         else if (cnt_inc) clk_cnt <= clk_cnt + 1'b1;
         if (rx_state == RX_IDLE) bit_cnt <= 3'd0;
         else if (sample_data)    bit_cnt <= bit_cnt + 3'd1;
         if (sample_data) rx_byte <= {rx_s, rx_byte[7:1]};
         if (stop_bad)      frame_error <= 1'b1;
         else if (len_load) frame_error <= 1'b0;
      end
   end

   // rx_byte stays stable through the byte_valid cycle, so the packet layer reads it directly.
   always_comb begin
      pk_next    = pk_state;
      len_load   = 1'b0;
      len_bad    = 1'b0;
      data_write = 1'b0;
      csum_ok    = 1'b0;
      csum_bad   = 1'b0;
      case (pk_state)
         P_LEN: begin
            if (byte_valid) begin
               if (rx_byte != 8'd0 && rx_byte <= 8'd32) begin
                  len_load = 1'b1;
                  pk_next  = P_DATA;
               end else begin
                  len_bad = 1'b1;
               end
            end
         end
         P_DATA: begin
            if (byte_abort) begin
               pk_next = P_LEN;
            end else if (byte_valid) begin
               data_write = 1'b1;
               if (idx + 6'd1 == len) pk_next = P_CSUM;
            end
         end
         P_CSUM: begin
            if (byte_abort) begin
               pk_next = P_LEN;
            end else if (byte_valid) begin
               if (rx_byte == sum) csum_ok  = 1'b1;
               else                csum_bad = 1'b1;
               pk_next = P_LEN;
            end
         end
         default: pk_next = P_LEN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prog_data_in      <= 8'd0;
         prog_addr         <= 5'd0;
         prog_write_enable <= 1'b0;
         start_execution   <= 1'b0;
         len               <= 6'd0;
         idx               <= 6'd0;
         sum               <= 8'd0;
         proto_error       <= 1'b0;
      end else begin
         prog_write_enable <= data_write;
         start_execution   <= csum_ok;
         if (len_load) begin
            len <= rx_byte[5:0];
            idx <= 6'd0;
            sum <= 8'd0;
         end
         if (data_write) begin
            prog_data_in <= rx_byte;
            prog_addr    <= idx[4:0];
            sum          <= sum + rx_byte;
            idx          <= idx + 6'd1;
         end
         if (len_bad || csum_bad) proto_error <= 1'b1;
         else if (len_load)       proto_error <= 1'b0;
      end
   end

   assign busy = (rx_state != RX_IDLE) || (pk_state != P_LEN);

endmodule

// File: tb/tb_serial_program_loader.sv
// tb/tb_serial_program_loader.sv - serial packet stimulus checked against a packet-level reference model
module tb_serial_program_loader;

   localparam int CPB = 16;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_serial;
   logic [7:0] prog_data_in;
   logic [4:0] prog_addr;
   logic       prog_write_enable;
   logic       start_execution;
   logic       busy;
   logic       frame_error;
   logic       proto_error;

   serial_program_loader #(.CLKS_PER_BIT(CPB)) dut (
      .clock             (clock),
      .reset             (reset),
      .rx_serial         (rx_serial),
      .prog_data_in      (prog_data_in),
      .prog_addr         (prog_addr),
      .prog_write_enable (prog_write_enable),
      .start_execution   (start_execution),
      .busy              (busy),
      .frame_error       (frame_error),
      .proto_error       (proto_error)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Observed strobes
   logic [4:0] got_addr[$];
   logic [7:0] got_data[$];
   int         got_starts = 0;
   int         overlap_cnt = 0;
   int         width_cnt = 0;
   logic       prev_we = 1'b0;
   logic       prev_st = 1'b0;

   always @(negedge clock) begin
      if (prog_write_enable) begin
         got_addr.push_back(prog_addr);
         got_data.push_back(prog_data_in);
      end
      if (start_execution) got_starts++;
      if (prog_write_enable && start_execution) overlap_cnt++;
      if ((prog_write_enable && prev_we) || (start_execution && prev_st)) width_cnt++;
      prev_we = prog_write_enable;
      prev_st = start_execution;
   end

   // Reference model: consumes whole received bytes, produces expected writes, starts and flags
   logic [4:0] exp_addr[$];
   logic [7:0] exp_data[$];
   int         m_starts = 0;
   int         m_phase = 0;
   int         m_len = 0;
   int         m_n = 0;
   logic [7:0] m_sum = 8'd0;
   logic       m_fe = 1'b0;
   logic       m_pe = 1'b0;

   task automatic model_byte(input logic [7:0] b, input logic ok);
      if (!ok) begin
         m_fe    = 1'b1;
         m_phase = 0;
      end else if (m_phase == 0) begin
         if (b >= 8'd1 && b <= 8'd32) begin
            m_len = int'(b); m_n = 0; m_sum = 8'd0;
            m_fe = 1'b0; m_pe = 1'b0; m_phase = 1;
         end else begin
            m_pe = 1'b1;
         end
      end else if (m_phase == 1) begin
         exp_addr.push_back(5'(m_n));
         exp_data.push_back(b);
         m_sum = m_sum + b;
         m_n++;
         if (m_n == m_len) m_phase = 2;
      end else begin
         if (b == m_sum) m_starts++;
         else            m_pe = 1'b1;
         m_phase = 0;
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_fe = 1'b0; m_pe = 1'b0;
   endtask

   task automatic drive_bit(input logic v);
      rx_serial = v;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_good);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_good);
      drive_bit(1'b1);
      drive_bit(1'b1);
      model_byte(b, stop_good);
   endtask

   task automatic compare_scenario(input string tag);
      int n;
      check_eq({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
         check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      end
      check_eq({tag, "_starts"}, got_starts, m_starts);
      check_eq({tag, "_frame_error"}, frame_error, m_fe);
      check_eq({tag, "_proto_error"}, proto_error, m_pe);
      check_eq({tag, "_busy"}, busy, m_phase != 0);
      got_addr.delete(); got_data.delete(); exp_addr.delete(); exp_data.delete();
      got_starts = 0; m_starts = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data"},  prog_data_in, 0);
      check_eq({tag, "_addr"},  prog_addr, 0);
      check_eq({tag, "_we"},    prog_write_enable, 0);
      check_eq({tag, "_start"}, start_execution, 0);
      check_eq({tag, "_busy"},  busy, 0);
      check_eq({tag, "_fe"},    frame_error, 0);
      check_eq({tag, "_pe"},    proto_error, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d, s;
      int         len, k;
      logic       seen_busy;

      reset = 1'b1;
      rx_serial = 1'b1;
      repeat (3) @(negedge clock);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (4) @(negedge clock);

      send_byte(8'h03, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
      send_byte(8'h33, 1); send_byte(8'h66, 1);
      compare_scenario("basic");

      send_byte(8'h02, 1); send_byte(8'h80, 1); send_byte(8'h90, 1); send_byte(8'h11, 1);
      compare_scenario("badcsum");

      send_byte(8'h20, 1);
      for (int i = 0; i < 32; i++) send_byte(8'(i), 1);
      send_byte(8'hF0, 1);
      compare_scenario("full");

      send_byte(8'h02, 1); send_byte(8'hAA, 1); send_byte(8'hBB, 0);
      compare_scenario("frameerr");
      send_byte(8'h01, 1); send_byte(8'h05, 1); send_byte(8'h05, 1);
      compare_scenario("frame_recover");

      send_byte(8'h21, 1);
      compare_scenario("badlen");

      // Reset in the middle of a data bit of the second data byte
      send_byte(8'h02, 1); send_byte(8'h44, 1);
      drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
      rx_serial = 1'b1;
      repeat (CPB / 2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_all_zero("midreset");
      reset = 1'b0;
      model_reset();
      repeat (2 * CPB) @(negedge clock);
      compare_scenario("midreset");
      send_byte(8'h01, 1); send_byte(8'h7F, 1); send_byte(8'h7F, 1);
      compare_scenario("after_reset");

      // Short low pulse must not be taken as a start bit
      rx_serial = 1'b0;
      repeat (3) @(negedge clock);
      rx_serial = 1'b1;
      seen_busy = 1'b0;
      k = 0;
      while (k < CPB / 2 + 3) begin
         if (busy) seen_busy = 1'b1;
         else if (seen_busy) break;
         @(negedge clock);
         k++;
      end
      check_eq("glitch_seen_busy", seen_busy, 1'b1);
      check_eq("glitch_busy_clear", busy, 1'b0);
      repeat (2 * CPB) @(negedge clock);
      compare_scenario("glitch");

      for (int p = 0; p < 6; p++) begin
         if ($urandom_range(0, 5) == 0) begin
            d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(33, 255));
            send_byte(d, 1);
         end else begin
            len = $urandom_range(1, 8);
            send_byte(8'(len), 1);
            s = 8'd0;
            for (int i = 0; i < len; i++) begin
               d = 8'($urandom);
               s = s + d;
               send_byte(d, $urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
            send_byte(s, 1);
         end
         compare_scenario($sformatf("rand%0d", p));
      end

      check_eq("strobe_overlap", overlap_cnt, 0);
      check_eq("strobe_width", width_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
